// File: rtl/reg_fifo_sync.sv
// Synchronous register-bank FIFO with registered read data and count-decoded flags.
// Optional sticky overflow/underflow flags are enabled by defining REG_FIFO_ERR_FLAGS_EN.
module reg_fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Re,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
`ifdef REG_FIFO_ERR_FLAGS_EN
  output logic             ovf,
  output logic             udf,
`endif
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A simultaneous read frees a slot, so a write into a full FIFO is still accepted.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!Re && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (Re) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef REG_FIFO_ERR_FLAGS_EN
  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (Re) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) begin
        ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule
